// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, parity modes and FSM states.
// Used by both the transmitter and the receiver on the same link.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding buffer feeding an LSB-first shifter.
// Bit timing comes from an external 16x oversample tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = PAR_NONE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_valid,
    input  logic [7:0] din,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_done_tick,
    output logic       busy
);

    localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] DATA_LAST = 3'(DBIT - 1);

    state_t            state;
    logic [4:0]        tick;
    logic [2:0]        bitn;
    logic [DBIT-1:0]   shreg;
    logic              par_bit;
    logic [7:0]        hold;
    logic              full;

    function automatic logic calc_par(input logic [DBIT-1:0] d);
        return (^d) ^ (PARITY == PAR_ODD);
    endfunction

    assign tx_ready = ~full;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            tick         <= '0;
            bitn         <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            hold         <= '0;
            full         <= 1'b0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            if (tx_valid && !full) begin
                hold <= din;
                full <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (full) begin
                        state   <= ST_START;
                        full    <= 1'b0;
                        shreg   <= hold[DBIT-1:0];
                        par_bit <= calc_par(hold[DBIT-1:0]);
                        tick    <= '0;
                        tx      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (tick == BIT_LAST) begin
                            tick  <= '0;
                            bitn  <= '0;
                            state <= ST_DATA;
                            tx    <= shreg[0];
                        end else begin
                            tick <= tick + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (tick == BIT_LAST) begin
                            tick  <= '0;
                            shreg <= shreg >> 1;
                            if (bitn == DATA_LAST) begin
                                if (PARITY != PAR_NONE) begin
                                    state <= ST_PAR;
                                    tx    <= par_bit;
                                end else begin
                                    state <= ST_STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bitn <= bitn + 3'd1;
                                tx   <= shreg[1];
                            end
                        end else begin
                            tick <= tick + 5'd1;
                        end
                    end
                end
                ST_PAR: begin
                    if (s_tick) begin
                        if (tick == BIT_LAST) begin
                            tick  <= '0;
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            tick <= tick + 5'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (s_tick) begin
                        if (tick == STOP_LAST) begin
                            tick         <= '0;
                            tx_done_tick <= 1'b1;
                            // a queued byte starts with no idle gap
                            if (full) begin
                                state   <= ST_START;
                                full    <= 1'b0;
                                shreg   <= hold[DBIT-1:0];
                                par_bit <= calc_par(hold[DBIT-1:0]);
                                tx      <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                                tx    <= 1'b1;
                            end
                        end else begin
                            tick <= tick + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three parameterisations share clock and tick,
// a tick-counting serial decoder checks each frame bit by bit.
module tb_uart_tx;

    typedef struct {
        int         k;
        logic [7:0] d;
        logic [7:0] exp_d;
        logic       exp_p;
        int         div;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick = 1'b0;
    logic [7:0] din;
    logic       valid   [3];
    logic       tx_w    [3];
    logic       ready_w [3];
    logic       done_w  [3];
    logic       busy_w  [3];

    int nerr = 0;
    int nchk = 0;
    int tcount = 0;
    int div = 1;
    int phase = 0;
    int done_cnt [3] = '{0, 0, 0};
    int exp_done [3] = '{0, 0, 0};
    logic prev_done [3] = '{1'b0, 1'b0, 1'b0};
    int wide_err = 0;

    int dbit_of [3] = '{8, 8, 7};
    bit has_par [3] = '{1'b0, 1'b1, 1'b1};
    int sb_of   [3] = '{16, 32, 24};
    int len_of  [3] = '{160, 192, 168};

    int   unstable, ready_hi, busy_lo, last_t;
    logic last_tx;
    bit   tmo;

    vec_t vecs [9];

    uart_tx u0 (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .tx_valid(valid[0]), .din(din), .tx_ready(ready_w[0]),
        .tx(tx_w[0]), .tx_done_tick(done_w[0]), .busy(busy_w[0])
    );

    uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY(1)) u1 (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .tx_valid(valid[1]), .din(din), .tx_ready(ready_w[1]),
        .tx(tx_w[1]), .tx_done_tick(done_w[1]), .busy(busy_w[1])
    );

    uart_tx #(.DBIT(7), .SB_TICK(24), .PARITY(2)) u2 (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .tx_valid(valid[2]), .din(din), .tx_ready(ready_w[2]),
        .tx(tx_w[2]), .tx_done_tick(done_w[2]), .busy(busy_w[2])
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (phase + 1 >= div) begin
            phase  <= 0;
            s_tick <= 1'b1;
        end else begin
            phase  <= phase + 1;
            s_tick <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (s_tick) tcount <= tcount + 1;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_w[k]) begin
                done_cnt[k] <= done_cnt[k] + 1;
                if (prev_done[k]) wide_err <= wide_err + 1;
            end
            prev_done[k] <= done_w[k];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_until(input int k, input int target);
        int g = 0;
        while (tcount < target && g < 20000) begin
            @(negedge clk);
            g++;
            if (tcount == last_t && tx_w[k] !== last_tx) unstable++;
            if (ready_w[k]) ready_hi++;
            if (!busy_w[k]) busy_lo++;
            last_t  = tcount;
            last_tx = tx_w[k];
        end
        if (g >= 20000) tmo = 1'b1;
    endtask

    task automatic mon_start(input int k);
        unstable = 0;
        ready_hi = 0;
        busy_lo  = 0;
        tmo      = 1'b0;
        last_t   = tcount;
        last_tx  = tx_w[k];
    endtask

    task automatic send(input int k, input logic [7:0] d, output int ts);
        int g = 0;
        @(negedge clk);
        while (!ready_w[k] && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("send_wait", 32'(g < 20000), 1);
        din      = d;
        valid[k] = 1'b1;
        @(negedge clk);
        valid[k] = 1'b0;
        din      = ~d;
        chk("accept_ready_low", ready_w[k], 0);
        @(negedge clk);
        ts = tcount;
        chk("start_tx", tx_w[k], 0);
        chk("start_busy", busy_w[k], 1);
        chk("start_ready", ready_w[k], 1);
    endtask

    task automatic decode(input int k, input int ts, output logic [7:0] data,
                          output logic pbit, output logic frame_ok,
                          output int len);
        int   nb;
        int   g;
        logic bits [12];
        nb = 1 + dbit_of[k] + (has_par[k] ? 1 : 0);
        mon_start(k);
        for (int b = 0; b < nb; b++) begin
            wait_until(k, ts + 16 * b + 8);
            bits[b] = tx_w[k];
        end
        wait_until(k, ts + 16 * nb + sb_of[k] / 2);
        frame_ok = (bits[0] == 1'b0) && (tx_w[k] == 1'b1);
        data = 8'h00;
        for (int i = 0; i < dbit_of[k]; i++) data[i] = bits[i + 1];
        pbit = has_par[k] ? bits[nb - 1] : 1'b0;
        g = 0;
        while (!done_w[k] && g < 20000) begin
            @(negedge clk);
            g++;
            if (tcount == last_t && tx_w[k] !== last_tx) unstable++;
            last_t  = tcount;
            last_tx = tx_w[k];
        end
        if (g >= 20000) tmo = 1'b1;
        len = tcount - ts;
        exp_done[k]++;
    endtask

    initial begin
        int         ts, ts2, d0, lowcnt, len;
        logic [7:0] data;
        logic       pbit, fok;

        vecs[0] = '{0, 8'h55, 8'h55, 1'b0, 1};
        vecs[1] = '{1, 8'hA3, 8'hA3, 1'b0, 1};
        vecs[2] = '{1, 8'h00, 8'h00, 1'b0, 1};
        vecs[3] = '{1, 8'hFF, 8'hFF, 1'b0, 1};
        vecs[4] = '{1, 8'h07, 8'h07, 1'b1, 1};
        vecs[5] = '{2, 8'h87, 8'h07, 1'b0, 1};
        vecs[6] = '{2, 8'h07, 8'h07, 1'b0, 1};
        vecs[7] = '{2, 8'h00, 8'h00, 1'b1, 1};
        vecs[8] = '{0, 8'hC3, 8'hC3, 1'b0, 5};

        reset = 1'b0;
        din   = 8'h00;
        for (int k = 0; k < 3; k++) valid[k] = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d_tx", k), tx_w[k], 1);
            chk($sformatf("rst%0d_ready", k), ready_w[k], 1);
            chk($sformatf("rst%0d_done", k), done_w[k], 0);
            chk($sformatf("rst%0d_busy", k), busy_w[k], 0);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            div = vecs[i].div;
            repeat (6) @(negedge clk);
            send(vecs[i].k, vecs[i].d, ts);
            decode(vecs[i].k, ts, data, pbit, fok, len);
            chk($sformatf("v%0d_data", i), data, vecs[i].exp_d);
            if (has_par[vecs[i].k])
                chk($sformatf("v%0d_parity", i), pbit, vecs[i].exp_p);
            chk($sformatf("v%0d_framing", i), fok, 1);
            chk($sformatf("v%0d_len", i), len, len_of[vecs[i].k]);
            chk($sformatf("v%0d_stable", i), unstable, 0);
            chk($sformatf("v%0d_busy_low", i), busy_lo, 0);
            chk($sformatf("v%0d_timeout", i), tmo, 0);
            chk($sformatf("v%0d_idle_after", i), busy_w[vecs[i].k], 0);
        end

        div = 1;
        repeat (6) @(negedge clk);
        send(0, 8'h0F, ts);
        din      = 8'hF0;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        din      = 8'h00;
        chk("b2b_full", ready_w[0], 0);
        decode(0, ts, data, pbit, fok, len);
        chk("b2b1_data", data, 8'h0F);
        chk("b2b1_len", len, 160);
        chk("b2b1_ready_low", ready_hi, 0);
        chk("b2b1_busy", busy_lo, 0);
        chk("b2b_gap_tx", tx_w[0], 0);
        chk("b2b_gap_busy", busy_w[0], 1);
        ts2 = tcount;
        decode(0, ts2, data, pbit, fok, len);
        chk("b2b2_data", data, 8'hF0);
        chk("b2b2_len", len, 160);
        chk("b2b2_framing", fok, 1);
        chk("b2b2_busy", busy_lo, 0);
        chk("b2b_timeout", tmo, 0);

        repeat (6) @(negedge clk);
        send(0, 8'h5A, ts);
        din      = 8'hA5;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        mon_start(0);
        wait_until(0, ts + 16 * 3 + 8);
        chk("pre_rst_tx", tx_w[0], 0);
        chk("pre_rst_ready", ready_w[0], 0);
        d0 = done_cnt[0];
        #1 reset = 1'b0;
        #1;
        chk("async_rst_tx", tx_w[0], 1);
        chk("async_rst_ready", ready_w[0], 1);
        chk("async_rst_busy", busy_w[0], 0);
        repeat (10) @(negedge clk);
        reset  = 1'b1;
        lowcnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) lowcnt++;
        end
        chk("rst_discard", lowcnt, 0);
        chk("rst_no_done", done_cnt[0], d0);
        send(0, 8'h3C, ts);
        decode(0, ts, data, pbit, fok, len);
        chk("post_rst_data", data, 8'h3C);
        chk("post_rst_len", len, 160);
        chk("post_rst_framing", fok, 1);

        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("done_count%0d", k), done_cnt[k], exp_done[k]);
        chk("done_width", wide_err, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, companion to the UART receiver on the same serial link. Accepts parallel bytes over a valid/ready handshake, buffers one byte, and shifts frames out LSB-first: start bit, DBIT data bits, optional parity, stop bits. Bit timing comes from the shared 16x-oversample baud tick generator that also drives the receiver. Each start, data and parity bit lasts 16 ticks.

## Interface
- `DBIT`, default 8: number of data bits, legal 7 or 8; `din` bits at index DBIT and above are ignored.
- `SB_TICK`, default 16: stop duration in `s_tick` pulses; legal 16, 24 or 32, giving 1, 1.5 or 2 stop bits.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `s_tick` in 1: one-`clk`-wide pulse at 16x the baud rate.
- `tx_valid` in 1: `din` is valid.
- `din` in 8: byte to send.
- `tx_ready` out 1: the holding buffer is empty; a byte is accepted on a rising edge where `tx_valid && tx_ready`.
- `tx` out 1: serial line, registered, idles high.
- `tx_done_tick` out 1: one-cycle pulse when a frame's last stop tick completes.
- `busy` out 1: high while the FSM is not IDLE.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `tx_done_tick`=0, `busy`=0, state IDLE, tick counter 0, bit counter 0, buffer empty.
- Holding buffer:
  - One entry: an 8-bit register plus a full flag, with `tx_ready` = ~full.
  - An accepted byte is loaded and full is set.
  - The FSM drains the buffer into the shift register when it starts a frame, which clears full.
  - Load and drain are never simultaneous, because `tx_ready` is low whenever the buffer is full.
- Parity is computed when the buffer is drained: the XOR of `din[DBIT-1:0]` for even parity, inverted for odd parity.
- FSM states use 3-bit encoding: IDLE, START, DATA, PAR, STOP.
  - IDLE: `tx`=1. If the buffer is full, go to START on the next edge, drain the buffer, and clear the tick counter.
  - START: `tx`=0. Count `s_tick` pulses; on the 16th, clear the tick counter, clear the bit counter, and go to DATA.
  - DATA: `tx` = shift[0]. On the 16th tick, shift right. If the bit counter equals DBIT-1, go to PAR when PARITY≠0, otherwise to STOP. If not, increment the bit counter.
  - PAR: `tx` = parity bit. On the 16th tick, go to STOP.
  - STOP: `tx`=1. On the SB_TICK-th tick, pulse `tx_done_tick`. Then go to START (draining the buffer) if the buffer is full, otherwise to IDLE. Back-to-back frames therefore have no idle gap.
- Counter widths:
  - The tick counter is 5 bits, to cover SB_TICK up to 32, and wraps to 0 at each bit boundary.
  - The bit counter is 3 bits.
- Cycles without `s_tick` hold all state; `tx` is stable.
- Reset asserted mid-frame:
  - `tx` goes to 1 immediately (asynchronously) and the buffered byte is discarded.
  - No `tx_done_tick` is produced.
- `din` is sampled only on acceptance, so the source may change it freely afterwards.

## Timing
- Byte accepted at edge N while IDLE with the buffer empty:
  - Buffer is full after edge N, so `tx_ready`=0.
  - At edge N+1 the FSM enters START, `tx` falls, `busy`=1, and `tx_ready` returns to 1.
- Frame length in `s_tick` pulses: 16·(1+DBIT+(PARITY≠0)) + SB_TICK. With defaults this is 160.
- Bit boundaries align to the rising edge that samples the 16th `s_tick` of each bit; `tx` changes on that same edge.
- `tx_done_tick` is high for the single cycle after the edge that samples the last stop tick. `busy` falls on that same edge if the FSM returns to IDLE.
- A second byte may be accepted from the edge after START entry onwards. It starts exactly at the end of the current frame's stop period.

## Structure
- Shared package `uart_pkg`, also used by the receiver:
  - oversample constant 16;
  - PARITY encodings (none, even, odd);
  - FSM state encodings.
- No sub-module: the holding buffer, parity, FSM and shift register live in `uart_tx`.
- The baud tick generator stays external and is shared with the receiver.

## Test plan
- **Single frame:** defaults, `s_tick` every cycle, send 0x55. Then `tx` = 0 for 16 ticks, bits 1,0,1,0,1,0,1,0 at 16 ticks each, then 1 for 16 ticks. `tx_done_tick` pulses exactly 160 ticks after the start edge.
- **Loopback:** send 0xA3, 0x00, 0xFF with SB_TICK=32 into the receiver. Receiver `dout` matches each byte, and `tx_done_tick` count = 3.
- **Back-to-back:** send 0x0F, and offer 0xF0 as soon as `tx_ready` returns. The 0xF0 start bit begins on the edge immediately after 0x0F's last stop tick. `busy` stays 1 throughout, and `tx_ready`=0 from acceptance of 0xF0 until its start.
- **Parity:** PARITY=1, send 0x07 → parity bit 1. PARITY=2, send 0x07 → parity bit 0. DBIT=7 with `din`=0x87 → data bits are those of 0x07.
- **Reset mid-frame:** assert `reset` low during the third data bit. `tx`=1 and `tx_ready`=1 without waiting for a clock, and no `tx_done_tick` occurs. After release, 0x3C transmits correctly.
- **Sparse ticks:** `s_tick` every 5 clocks, send 0xC3 → frame occupies 800 clocks from start edge to `tx_done_tick`, and `tx` is stable between ticks.
